// File: rtl/clock_set_ctrl.sv
// HH:MM:SS time-of-day controller: one-second tick, BCD time registers,
// two-button set-time FSM and blink masks for the digit pair being edited.
module clock_set_ctrl #(
    parameter int TICK_N = 2_000_000,
    parameter int HALF_N = 1_000_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            btn_mode,
    input  logic            btn_inc,
    output logic [1:0][3:0] hour,
    output logic [1:0][3:0] minute,
    output logic [1:0][3:0] second,
    output logic [1:0]      mode,
    output logic [2:0]      blank
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        BAD   = 2'd3
    } state_t;

    localparam int TW = (TICK_N > 1) ? $clog2(TICK_N) : 1;
    localparam int HW = (HALF_N > 1) ? $clog2(HALF_N) : 1;

    state_t        state, state_next;
    logic          mode_q, inc_q;
    logic          mode_press, inc_press, tick;
    logic [TW-1:0] tick_cnt;
    logic [HW-1:0] blink_cnt;
    logic          phase;
    logic [4:0]    hour_bin;
    logic [3:0]    min_t, min_u, sec_t, sec_u;

    // A mode press in the same cycle swallows the increment press.
    always_comb begin
        mode_press = btn_mode & ~mode_q;
        inc_press  = btn_inc & ~inc_q & ~mode_press;
        tick       = (state == RUN) && (tick_cnt == TW'(TICK_N - 1));
        state_next = state;
        case (state)
            RUN:     if (mode_press) state_next = SET_H;
            SET_H:   if (mode_press) state_next = SET_M;
            SET_M:   if (mode_press) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // NOTE: every register here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            mode_q    <= 1'b0;
            inc_q     <= 1'b0;
            tick_cnt  <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            hour_bin  <= '0;
            min_t     <= '0;
            min_u     <= '0;
            sec_t     <= '0;
            sec_u     <= '0;
        end else begin
            state  <= state_next;
            mode_q <= btn_mode;
            inc_q  <= btn_inc;

            if (state == RUN && state_next == RUN)
                tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            else
                tick_cnt <= '0;

            // Any mode change restarts the blink so edited digits show at once.
            if (state_next != state || (state != SET_H && state != SET_M)) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_cnt == HW'(HALF_N - 1)) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + HW'(1);
            end

            case (state)
                RUN: if (tick) begin
                    if (sec_u != 4'd9) sec_u <= sec_u + 4'd1;
                    else begin
                        sec_u <= 4'd0;
                        if (sec_t != 4'd5) sec_t <= sec_t + 4'd1;
                        else begin
                            sec_t <= 4'd0;
                            if (min_u != 4'd9) min_u <= min_u + 4'd1;
                            else begin
                                min_u <= 4'd0;
                                if (min_t != 4'd5) min_t <= min_t + 4'd1;
                                else begin
                                    min_t    <= 4'd0;
                                    hour_bin <= (hour_bin == 5'd23) ? 5'd0 : hour_bin + 5'd1;
                                end
                            end
                        end
                    end
                end
                SET_H: begin
                    if (mode_press) begin
                        sec_t <= 4'd0;
                        sec_u <= 4'd0;
                    end else if (inc_press) begin
                        hour_bin <= (hour_bin == 5'd23) ? 5'd0 : hour_bin + 5'd1;
                    end
                end
                SET_M: if (inc_press) begin
                    if (min_u != 4'd9) min_u <= min_u + 4'd1;
                    else begin
                        min_u <= 4'd0;
                        min_t <= (min_t == 4'd5) ? 4'd0 : min_t + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        if (hour_bin >= 5'd20) begin
            hour[1] = 4'd2;
            hour[0] = 4'(hour_bin - 5'd20);
        end else if (hour_bin >= 5'd10) begin
            hour[1] = 4'd1;
            hour[0] = 4'(hour_bin - 5'd10);
        end else begin
            hour[1] = 4'd0;
            hour[0] = 4'(hour_bin);
        end
    end

    assign minute = {min_t, min_u};
    assign second = {sec_t, sec_u};
    assign mode   = state;
    assign blank  = {(state == SET_H) & phase, (state == SET_M) & phase, 1'b0};

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_N=4, HALF_N=2: stepped cycles,
// a vector table for the simultaneous-press and held-inc/blink sequences.
module tb_clock_set_ctrl;

    logic            clk = 1'b0;
    logic            reset, btn_mode, btn_inc;
    logic [1:0][3:0] hour, minute, second;
    logic [1:0]      mode;
    logic [2:0]      blank;

    int passed = 0;
    int total  = 0;

    clock_set_ctrl #(.TICK_N(4), .HALF_N(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .hour     (hour),
        .minute   (minute),
        .second   (second),
        .mode     (mode),
        .blank    (blank)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m;
        logic       i;
        logic [7:0] hh, mm, ss;
        logic [1:0] md;
        logic [2:0] bl;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s: got %h, required %h", name, got, exp);
        else
            passed++;
    endtask

    task automatic check_all(input string name, input logic [7:0] hh, input logic [7:0] mm,
                             input logic [7:0] ss, input logic [1:0] md, input logic [2:0] bl);
        check(name, 32'({hour, minute, second, mode, blank}), 32'({hh, mm, ss, md, bl}));
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step(input logic m, input logic i, input logic r);
        btn_mode = m;
        btn_inc  = i;
        reset    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic press_inc(input int n);
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            step(vecs[k].m, vecs[k].i, 1'b0);
            check_all($sformatf("vec%0d", k), vecs[k].hh, vecs[k].mm, vecs[k].ss,
                      vecs[k].md, vecs[k].bl);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int waited;

        // Simultaneous mode+inc from SET_H at 00:42:00.
        vecs[0]  = '{1, 1, 8'h00, 8'h42, 8'h00, 2'd2, 3'b000};
        // Enter SET_M at 00:07:00, hold inc 10 cycles, release.
        vecs[1]  = '{1, 0, 8'h00, 8'h07, 8'h00, 2'd2, 3'b000};
        vecs[2]  = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b000};
        vecs[3]  = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b010};
        vecs[4]  = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b010};
        vecs[5]  = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b000};
        vecs[6]  = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b000};
        vecs[7]  = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b010};
        vecs[8]  = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b010};
        vecs[9]  = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b000};
        vecs[10] = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b000};
        vecs[11] = '{0, 1, 8'h00, 8'h08, 8'h00, 2'd2, 3'b010};
        vecs[12] = '{0, 0, 8'h00, 8'h08, 8'h00, 2'd2, 3'b010};
        vecs[13] = '{0, 0, 8'h00, 8'h08, 8'h00, 2'd2, 3'b000};

        // 1. Reset then free-run.
        step(1'b0, 1'b0, 1'b1);
        check_all("reset_state", 8'h00, 8'h00, 8'h00, 2'd0, 3'b000);
        bad = 0;
        for (int c = 1; c <= 240; c++) begin
            step(1'b0, 1'b0, 1'b0);
            if (mode !== 2'd0 || blank !== 3'b000) bad++;
            if (c == 3)   check("run_pre_tick", 32'(second), 32'h00);
            if (c == 4)   check("run_first_tick", 32'(second), 32'h01);
            if (c == 236) check_all("run_00_00_59", 8'h00, 8'h00, 8'h59, 2'd0, 3'b000);
            if (c == 240) check_all("run_00_01_00", 8'h00, 8'h01, 8'h00, 2'd0, 3'b000);
        end
        check("run_mode_blank_bad_cycles", 32'(bad), 32'd0);

        // 2. Set 23:59 and roll over midnight.
        step(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 1'b0);
        check_all("pre_set_00_00_02", 8'h00, 8'h00, 8'h02, 2'd0, 3'b000);
        step(1'b1, 1'b0, 1'b0);
        check_all("enter_set_h", 8'h00, 8'h00, 8'h02, 2'd1, 3'b000);
        step(1'b0, 1'b0, 1'b0);
        press_inc(23);
        check("set_h_23", 32'({hour, second, mode}), 32'({8'h23, 8'h02, 2'd1}));
        step(1'b1, 1'b0, 1'b0);
        check_all("enter_set_m_clears_sec", 8'h23, 8'h00, 8'h00, 2'd2, 3'b000);
        step(1'b0, 1'b0, 1'b0);
        press_inc(59);
        check("set_m_59", 32'({hour, minute, second, mode}), 32'({8'h23, 8'h59, 8'h00, 2'd2}));
        step(1'b1, 1'b0, 1'b0);
        check_all("enter_run_23_59_00", 8'h23, 8'h59, 8'h00, 2'd0, 3'b000);
        for (int c = 1; c <= 240; c++) begin
            step(1'b0, 1'b0, 1'b0);
            if (c == 239) check_all("run_23_59_59", 8'h23, 8'h59, 8'h59, 2'd0, 3'b000);
            if (c == 240) check_all("midnight_wrap", 8'h00, 8'h00, 8'h00, 2'd0, 3'b000);
        end

        // 3. Hour 23 -> 00 in SET_H, minutes untouched, time frozen.
        press_mode();
        press_inc(23);
        press_mode();
        press_inc(42);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_all("set_h_at_23_42", 8'h23, 8'h42, 8'h00, 2'd1, 3'b000);
        step(1'b0, 1'b1, 1'b0);
        check_all("set_h_wrap_to_00", 8'h00, 8'h42, 8'h00, 2'd1, 3'b000);
        step(1'b0, 1'b0, 1'b0);
        check_all("set_h_blink_on", 8'h00, 8'h42, 8'h00, 2'd1, 3'b100);
        for (int c = 0; c < 50; c++) step(1'b0, 1'b0, 1'b0);
        check("set_h_frozen", 32'({hour, minute, second, mode}), 32'({8'h00, 8'h42, 8'h00, 2'd1}));

        // 4. Mode and inc together: mode wins.
        run_table(0, 0);
        step(1'b0, 1'b0, 1'b0);

        // 5. Held inc at minute 07 with blink from a fresh SET_M entry.
        press_inc(25);
        check("set_m_wrap_to_07", 32'({hour, minute, mode}), 32'({8'h00, 8'h07, 2'd2}));
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        run_table(1, 13);

        // 6. Reset in the middle of an edit.
        press_mode();
        press_mode();
        press_inc(12);
        press_mode();
        press_inc(26);
        waited = 0;
        while (blank[1] !== 1'b1 && waited < 4) begin
            step(1'b0, 1'b0, 1'b0);
            waited++;
        end
        check_all("set_m_12_34_blinking", 8'h12, 8'h34, 8'h00, 2'd2, 3'b010);
        step(1'b0, 1'b0, 1'b1);
        check_all("reset_mid_set", 8'h00, 8'h00, 8'h00, 2'd0, 3'b000);
        for (int c = 1; c <= 4; c++) begin
            step(1'b0, 1'b0, 1'b0);
            if (c == 3) check("post_reset_no_tick", 32'(second), 32'h00);
            if (c == 4) check("post_reset_tick", 32'({second, mode, blank}), 32'({8'h01, 2'd0, 3'b000}));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
